// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 8-digit scanner: 8x4 register file, IDLE/SHOW/GAP sequencer driving a 3-to-8 select decoder.
// Optional hex-to-7-segment output `seg` is compiled in when DIGIT_SCAN_SEG_EN is defined.
module digit_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [2:0] num_digits,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [2:0] sel,
    output logic       sel_en,
    output logic [3:0] digit
`ifdef DIGIT_SCAN_SEG_EN
    ,
    output logic [6:0] seg
`endif
);

    localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW       = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam int BLANK_M1 = (BLANK > 0) ? BLANK - 1 : 0;
    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_M1);

    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sel_q, sel_d, sel_adv;
    logic            sel_en_q, sel_en_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   gcnt_q, gcnt_d;
    logic [3:0]      mem_q [8];

    // Register file; cleared by reset so `digit` reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem_q[i] <= 4'h0;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 3'd0;
            sel_en_q <= 1'b0;
            cnt_q    <= '0;
            gcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
        end
    end

    // num_digits is only consulted here, so a shrink lands at the next advance.
    assign sel_adv = (sel_q >= num_digits) ? 3'd0 : sel_q + 3'd1;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        if (!run) begin
            state_d = IDLE;
            sel_d   = 3'd0;
            cnt_d   = '0;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    sel_d   = 3'd0;
                    cnt_d   = '0;
                end
                SHOW: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_d = '0;
                        if (BLANK > 0) begin
                            state_d = GAP;
                            gcnt_d  = '0;
                        end else begin
                            sel_d = sel_adv;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        sel_d   = sel_adv;
                        gcnt_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = 3'd0;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                end
            endcase
        end
    end

    // Enable is registered from the next state so the decoder never sees a decode glitch.
    assign sel_en_d = (state_d == SHOW);

    always_comb begin
        sel    = sel_q;
        sel_en = sel_en_q;
        digit  = mem_q[sel_q];
`ifdef DIGIT_SCAN_SEG_EN
        case (mem_q[sel_q])
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
`endif
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: DIV=3/BLANK=2 main instance plus a DIV=1/BLANK=0 instance.
module tb_digit_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, run2;
    logic [2:0] num_digits, num_digits2;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [2:0] sel, sel2;
    logic       sel_en, sel_en2;
    logic [3:0] digit, digit2;
`ifdef DIGIT_SCAN_SEG_EN
    logic [6:0] seg, seg2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DIV(3), .BLANK(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .num_digits(num_digits),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sel(sel), .sel_en(sel_en), .digit(digit)
`ifdef DIGIT_SCAN_SEG_EN
        , .seg(seg)
`endif
    );

    digit_scan_ctrl #(.DIV(1), .BLANK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run2), .num_digits(num_digits2),
        .wr_en(1'b0), .wr_addr(3'd0), .wr_data(4'd0),
        .sel(sel2), .sel_en(sel_en2), .digit(digit2)
`ifdef DIGIT_SCAN_SEG_EN
        , .seg(seg2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one SHOW/GAP period of digit d (3 cycles enabled, 2 blanked).
    task automatic scan_digit(input int d, input logic [3:0] val);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("show_en d%0d c%0d", d, c), sel_en, 1);
            check($sformatf("show_sel d%0d c%0d", d, c), sel, d);
            check($sformatf("show_digit d%0d c%0d", d, c), digit, val);
            step();
        end
        for (int c = 0; c < 2; c++) begin
            check($sformatf("gap_en d%0d c%0d", d, c), sel_en, 0);
            check($sformatf("gap_sel d%0d c%0d", d, c), sel, d);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; run2 = 1'b0;
        num_digits = 3'd0; num_digits2 = 3'd2;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;

        // Reset and idle
        repeat (3) step();
        check("rst_sel", sel, 0);
        check("rst_en", sel_en, 0);
        check("rst_digit", digit, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_sel", sel, 0);
            check("idle_en", sel_en, 0);
            check("idle_digit", digit, 0);
`ifdef DIGIT_SCAN_SEG_EN
            check("idle_seg", seg, 7'h3F);
`endif
        end

        // Fill register file with mem[i]=i
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i);
            step();
        end
        wr_en = 1'b0;
        check("idle_after_wr_en", sel_en, 0);

        // Basic scan over all eight digits
        num_digits = 3'd7; run = 1'b1;
        step();
        for (int d = 0; d < 8; d++) scan_digit(d, 4'(d));
        check("wrap_sel", sel, 0);
        check("wrap_en", sel_en, 1);

        // Shrink num_digits while sel=5
        for (int d = 0; d < 5; d++) scan_digit(d, 4'(d));
        check("at5_sel", sel, 5);
        num_digits = 3'd3;
        scan_digit(5, 4'd5);
        for (int d = 0; d < 4; d++) scan_digit(d, 4'(d));
        check("shrink_wrap_sel", sel, 0);
        check("shrink_wrap_en", sel_en, 1);

        // Live write to the selected digit
        scan_digit(0, 4'd0);
        scan_digit(1, 4'd1);
        check("live_pre_sel", sel, 2);
        check("live_pre_digit", digit, 2);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hA;
        step();
        wr_en = 1'b0;
        check("live_digit", digit, 4'hA);
        check("live_sel", sel, 2);
        check("live_en", sel_en, 1);
`ifdef DIGIT_SCAN_SEG_EN
        check("live_seg", seg, 7'h77);
`endif
        num_digits = 3'd7;

        // Walk to sel=4, one cycle into its dwell, then abort
        repeat (10) step();
        check("abort_pre_sel", sel, 4);
        check("abort_pre_en", sel_en, 1);
        run = 1'b0;
        step();
        check("abort_en", sel_en, 0);
        check("abort_sel", sel, 0);
        step();
        check("abort_idle_en", sel_en, 0);
        run = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("restart_en c%0d", c), sel_en, 1);
            check($sformatf("restart_sel c%0d", c), sel, 0);
            step();
        end
        check("restart_gap_en", sel_en, 0);

        // Asynchronous reset mid-GAP
        rst_n = 1'b0;
        #1;
        check("arst_en", sel_en, 0);
        check("arst_sel", sel, 0);
        check("arst_digit", digit, 0);
        run = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        run = 1'b1;
        step();
        scan_digit(0, 4'd0);
        scan_digit(1, 4'd0);
        check("cleared_sel", sel, 2);
        check("cleared_digit2", digit, 0);
`ifdef DIGIT_SCAN_SEG_EN
        check("cleared_seg", seg, 7'h3F);
`endif
        run = 1'b0;

        // BLANK=0, DIV=1 instance: select advances every cycle, enable stays high
        run2 = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("b0_en i%0d", i), sel_en2, 1);
            check($sformatf("b0_sel i%0d", i), sel2, i % 3);
            check($sformatf("b0_digit i%0d", i), digit2, 0);
            step();
        end
        run2 = 1'b0;
        step();
        check("b0_stop_en", sel_en2, 0);
        check("b0_stop_sel", sel2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
